// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz setup controller and the display block.
// cur_field carries these state codes directly.
package quiz_pkg;

    localparam int FIELD_W = 3;

    typedef enum logic [FIELD_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PEOPLE  = 3'd1,
        ST_SEC     = 3'd2,
        ST_CORRECT = 3'd3,
        ST_MISTAKE = 3'd4,
        ST_CONFIRM = 3'd5
    } state_t;

endpackage

// File: rtl/btn_rise.sv
// Rising-edge detector for a debounced, synchronous button.
// A button already held when reset is released is ignored until it has been seen low.
module btn_rise (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev_reg;
    logic armed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            prev_reg  <= btn;
            armed_reg <= armed_reg | ~btn;
        end
    end

    assign press = btn & ~prev_reg & armed_reg;

endmodule

// File: rtl/quiz_setup_ctrl.sv
// Setup controller: four range-checked entries with back-stepping, committed
// together on a final confirm so downstream blocks never see a partial edit.
module quiz_setup_ctrl
    import quiz_pkg::*;
#(
    parameter int VAL_W       = 6,
    parameter int PLAYERS_MIN = 2,
    parameter int PLAYERS_MAX = 4,
    parameter int SEC_MIN     = 1,
    parameter int SEC_MAX     = 2**VAL_W-1,
    parameter int PT_MIN      = 1,
    parameter int PT_MAX      = 2**VAL_W-1,
    parameter int DEF_PLAYERS = 2,
    parameter int DEF_SEC     = 10,
    parameter int DEF_CORRECT = 1,
    parameter int DEF_MISTAKE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               setting_en,
    input  logic               enter_btn,
    input  logic               back_btn,
    input  logic [VAL_W-1:0]   input_val,
    output logic [VAL_W-1:0]   num_people,
    output logic [VAL_W-1:0]   count_seconds,
    output logic [VAL_W-1:0]   correct_point,
    output logic [VAL_W-1:0]   mistake_point,
    output logic [FIELD_W-1:0] cur_field,
    output logic               is_set_over,
    output logic               reject,
    output logic               commit
);

    localparam logic [VAL_W-1:0] DEF_VALS [4] = '{
        VAL_W'(DEF_PLAYERS), VAL_W'(DEF_SEC), VAL_W'(DEF_CORRECT), VAL_W'(DEF_MISTAKE)
    };

    logic enter_press;
    logic back_press;

    btn_rise u_enter_rise (.clk(clk), .rst(rst), .btn(enter_btn), .press(enter_press));
    btn_rise u_back_rise  (.clk(clk), .rst(rst), .btn(back_btn),  .press(back_press));

    state_t           state_reg;
    logic [VAL_W-1:0] shadow_reg    [4];
    logic [VAL_W-1:0] committed_reg [4];
    logic             is_set_over_reg;
    logic             reject_reg;
    logic             commit_reg;

    // Entry fields S_PEOPLE..S_MISTAKE map onto array slots 0..3.
    logic [1:0] field_idx;
    assign field_idx = 2'(state_reg - ST_PEOPLE);

    logic [VAL_W-1:0] lim_lo;
    logic [VAL_W-1:0] lim_hi;
    logic             in_range;

    always_comb begin
        lim_lo = VAL_W'(PLAYERS_MIN);
        lim_hi = VAL_W'(PLAYERS_MAX);
        case (state_reg)
            ST_SEC: begin
                lim_lo = VAL_W'(SEC_MIN);
                lim_hi = VAL_W'(SEC_MAX);
            end
            ST_CORRECT, ST_MISTAKE: begin
                lim_lo = VAL_W'(PT_MIN);
                lim_hi = VAL_W'(PT_MAX);
            end
            default: ;
        endcase
        in_range = (input_val >= lim_lo) && (input_val <= lim_hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            is_set_over_reg <= 1'b1;
            reject_reg      <= 1'b0;
            commit_reg      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_reg[i]    <= DEF_VALS[i];
                committed_reg[i] <= DEF_VALS[i];
            end
        end else begin
            reject_reg <= 1'b0;
            commit_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (setting_en) begin
                    shadow_reg      <= committed_reg;
                    state_reg       <= ST_PEOPLE;
                    is_set_over_reg <= 1'b0;
                end
            end else if (!setting_en) begin
                state_reg       <= ST_IDLE;
                is_set_over_reg <= 1'b1;
            end else if (back_press) begin
                // Back beats a simultaneous enter; it is a no-op on the first field.
                if (state_reg != ST_PEOPLE)
                    state_reg <= state_t'(state_reg - 3'd1);
            end else if (enter_press) begin
                if (state_reg == ST_CONFIRM) begin
                    committed_reg   <= shadow_reg;
                    commit_reg      <= 1'b1;
                    state_reg       <= ST_IDLE;
                    is_set_over_reg <= 1'b1;
                end else if (in_range) begin
                    shadow_reg[field_idx] <= input_val;
                    state_reg             <= state_t'(state_reg + 3'd1);
                end else begin
                    reject_reg <= 1'b1;
                end
            end
        end
    end

    assign num_people    = committed_reg[0];
    assign count_seconds = committed_reg[1];
    assign correct_point = committed_reg[2];
    assign mistake_point = committed_reg[3];
    assign cur_field     = state_reg;
    assign is_set_over   = is_set_over_reg;
    assign reject        = reject_reg;
    assign commit        = commit_reg;

endmodule

// File: tb/tb_quiz_setup_ctrl.sv
// Directed bench for quiz_setup_ctrl: one task per scenario, inline comparisons.
module tb_quiz_setup_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setting_en = 1'b0;
    logic       enter_btn = 1'b0;
    logic       back_btn = 1'b0;
    logic [5:0] input_val = '0;
    logic [5:0] num_people, count_seconds, correct_point, mistake_point;
    logic [2:0] cur_field;
    logic       is_set_over, reject, commit;

    int n_cmp = 0;
    int n_bad = 0;
    int commit_cnt = 0;
    int cnt0;

    quiz_setup_ctrl dut (
        .clk(clk), .rst(rst), .setting_en(setting_en), .enter_btn(enter_btn),
        .back_btn(back_btn), .input_val(input_val), .num_people(num_people),
        .count_seconds(count_seconds), .correct_point(correct_point),
        .mistake_point(mistake_point), .cur_field(cur_field),
        .is_set_over(is_set_over), .reject(reject), .commit(commit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit) commit_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One low cycle, then a single-cycle enter pulse; returns just after the press edge.
    task automatic press_enter(input logic [5:0] v);
        tick();
        input_val = v;
        enter_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
    endtask

    task automatic press_back();
        tick();
        back_btn = 1'b1;
        tick();
        back_btn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        setting_en = 1'b0;
        enter_btn = 1'b0;
        back_btn = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({num_people, count_seconds, correct_point, mistake_point} !== {6'd2, 6'd10, 6'd1, 6'd1}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0d/%0d/%0d/%0d want 2/10/1/1",
                     num_people, count_seconds, correct_point, mistake_point);
        end
        n_cmp++;
        if ({cur_field, is_set_over, reject, commit} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_status: got field=%0d over=%b rej=%b com=%b want 0/1/0/0",
                     cur_field, is_set_over, reject, commit);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_entry();
        cnt0 = commit_cnt;
        setting_en = 1'b1;
        tick();
        n_cmp++;
        if ({cur_field, is_set_over} !== {3'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL enter_setup: got field=%0d over=%b want 1/0", cur_field, is_set_over);
        end
        press_enter(6'd3);
        press_enter(6'd20);
        press_enter(6'd5);
        press_enter(6'd2);
        n_cmp++;
        if (cur_field !== 3'd5) begin
            n_bad++;
            $display("FAIL reach_confirm: got field=%0d want 5", cur_field);
        end
        n_cmp++;
        if (num_people !== 6'd2) begin
            n_bad++;
            $display("FAIL no_early_commit: got num_people=%0d want 2", num_people);
        end
        press_enter(6'd0);
        setting_en = 1'b0;
        n_cmp++;
        if ({commit, is_set_over, cur_field} !== {1'b1, 1'b1, 3'd0}) begin
            n_bad++;
            $display("FAIL confirm_status: got com=%b over=%b field=%0d want 1/1/0",
                     commit, is_set_over, cur_field);
        end
        n_cmp++;
        if ({num_people, count_seconds, correct_point, mistake_point} !== {6'd3, 6'd20, 6'd5, 6'd2}) begin
            n_bad++;
            $display("FAIL confirm_outputs: got %0d/%0d/%0d/%0d want 3/20/5/2",
                     num_people, count_seconds, correct_point, mistake_point);
        end
        tick();
        n_cmp++;
        if (commit !== 1'b0 || commit_cnt - cnt0 != 1) begin
            n_bad++;
            $display("FAIL commit_once: got com=%b pulses=%0d want 0/1", commit, commit_cnt - cnt0);
        end
        $display("test_full_entry done");
    endtask

    task automatic test_range();
        setting_en = 1'b1;
        tick();
        press_enter(6'd5);
        n_cmp++;
        if ({reject, cur_field, num_people} !== {1'b1, 3'd1, 6'd3}) begin
            n_bad++;
            $display("FAIL reject_high: got rej=%b field=%0d np=%0d want 1/1/3",
                     reject, cur_field, num_people);
        end
        tick();
        n_cmp++;
        if (reject !== 1'b0) begin
            n_bad++;
            $display("FAIL reject_one_cycle: got rej=%b want 0", reject);
        end
        press_enter(6'd1);
        n_cmp++;
        if ({reject, cur_field} !== {1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL reject_low: got rej=%b field=%0d want 1/1", reject, cur_field);
        end
        press_enter(6'd4);
        n_cmp++;
        if ({reject, cur_field} !== {1'b0, 3'd2}) begin
            n_bad++;
            $display("FAIL accept_max_players: got rej=%b field=%0d want 0/2", reject, cur_field);
        end
        press_enter(6'd0);
        n_cmp++;
        if ({reject, cur_field} !== {1'b1, 3'd2}) begin
            n_bad++;
            $display("FAIL reject_sec_zero: got rej=%b field=%0d want 1/2", reject, cur_field);
        end
        press_enter(6'd63);
        n_cmp++;
        if ({reject, cur_field} !== {1'b0, 3'd3}) begin
            n_bad++;
            $display("FAIL accept_sec_63: got rej=%b field=%0d want 0/3", reject, cur_field);
        end
        press_enter(6'd0);
        n_cmp++;
        if ({reject, cur_field} !== {1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL reject_pt_zero: got rej=%b field=%0d want 1/3", reject, cur_field);
        end
        setting_en = 1'b0;
        tick();
        n_cmp++;
        if ({cur_field, is_set_over, num_people, count_seconds} !== {3'd0, 1'b1, 6'd3, 6'd20}) begin
            n_bad++;
            $display("FAIL range_abort: got field=%0d over=%b np=%0d sec=%0d want 0/1/3/20",
                     cur_field, is_set_over, num_people, count_seconds);
        end
        $display("test_range done");
    endtask

    task automatic test_back();
        setting_en = 1'b1;
        tick();
        press_enter(6'd3);
        press_enter(6'd20);
        press_back();
        n_cmp++;
        if (cur_field !== 3'd2) begin
            n_bad++;
            $display("FAIL back_one: got field=%0d want 2", cur_field);
        end
        press_back();
        n_cmp++;
        if (cur_field !== 3'd1) begin
            n_bad++;
            $display("FAIL back_two: got field=%0d want 1", cur_field);
        end
        press_back();
        n_cmp++;
        if (cur_field !== 3'd1) begin
            n_bad++;
            $display("FAIL back_at_first: got field=%0d want 1", cur_field);
        end
        press_enter(6'd2);
        n_cmp++;
        if (cur_field !== 3'd2) begin
            n_bad++;
            $display("FAIL reenter_people: got field=%0d want 2", cur_field);
        end
        press_enter(6'd20);
        press_enter(6'd6);
        press_enter(6'd7);
        press_back();
        n_cmp++;
        if (cur_field !== 3'd4) begin
            n_bad++;
            $display("FAIL back_from_confirm: got field=%0d want 4", cur_field);
        end
        press_enter(6'd7);
        press_enter(6'd0);
        setting_en = 1'b0;
        n_cmp++;
        if ({commit, num_people, count_seconds, correct_point, mistake_point} !== {1'b1, 6'd2, 6'd20, 6'd6, 6'd7}) begin
            n_bad++;
            $display("FAIL back_commit: got com=%b %0d/%0d/%0d/%0d want 1 2/20/6/7",
                     commit, num_people, count_seconds, correct_point, mistake_point);
        end
        tick();
        $display("test_back done");
    endtask

    task automatic test_abort();
        do_reset();
        cnt0 = commit_cnt;
        setting_en = 1'b1;
        tick();
        press_enter(6'd4);
        press_enter(6'd30);
        press_enter(6'd9);
        n_cmp++;
        if (cur_field !== 3'd4) begin
            n_bad++;
            $display("FAIL abort_setup: got field=%0d want 4", cur_field);
        end
        setting_en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({cur_field, is_set_over} !== {3'd0, 1'b1} || commit_cnt != cnt0) begin
            n_bad++;
            $display("FAIL abort_state: got field=%0d over=%b commits=%0d want 0/1/0",
                     cur_field, is_set_over, commit_cnt - cnt0);
        end
        n_cmp++;
        if ({num_people, count_seconds, correct_point, mistake_point} !== {6'd2, 6'd10, 6'd1, 6'd1}) begin
            n_bad++;
            $display("FAIL abort_outputs: got %0d/%0d/%0d/%0d want 2/10/1/1",
                     num_people, count_seconds, correct_point, mistake_point);
        end
        $display("test_abort done");
    endtask

    task automatic test_hold();
        setting_en = 1'b1;
        tick();
        press_enter(6'd3);
        tick();
        input_val = 6'd15;
        enter_btn = 1'b1;
        repeat (50) tick();
        n_cmp++;
        if ({cur_field, reject} !== {3'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_single_advance: got field=%0d rej=%b want 3/0", cur_field, reject);
        end
        enter_btn = 1'b0;
        press_enter(6'd9);
        press_enter(6'd8);
        press_enter(6'd0);
        setting_en = 1'b0;
        n_cmp++;
        if ({num_people, count_seconds, correct_point, mistake_point} !== {6'd3, 6'd15, 6'd9, 6'd8}) begin
            n_bad++;
            $display("FAIL hold_commit: got %0d/%0d/%0d/%0d want 3/15/9/8",
                     num_people, count_seconds, correct_point, mistake_point);
        end
        tick();
        $display("test_hold done");
    endtask

    task automatic test_simultaneous();
        setting_en = 1'b1;
        tick();
        press_enter(6'd2);
        press_enter(6'd12);
        tick();
        input_val = 6'd0;
        enter_btn = 1'b1;
        back_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
        back_btn = 1'b0;
        n_cmp++;
        if ({cur_field, reject} !== {3'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL enter_back_together: got field=%0d rej=%b want 2/0", cur_field, reject);
        end
        setting_en = 1'b0;
        tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        setting_en = 1'b1;
        tick();
        press_enter(6'd4);
        press_enter(6'd40);
        press_enter(6'd3);
        press_enter(6'd3);
        n_cmp++;
        if (cur_field !== 3'd5) begin
            n_bad++;
            $display("FAIL mid_reach_confirm: got field=%0d want 5", cur_field);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setting_en = 1'b0;
        n_cmp++;
        if ({cur_field, is_set_over, num_people, count_seconds, correct_point, mistake_point} !==
            {3'd0, 1'b1, 6'd2, 6'd10, 6'd1, 6'd1}) begin
            n_bad++;
            $display("FAIL reset_mid_entry: got field=%0d over=%b %0d/%0d/%0d/%0d want 0/1 2/10/1/1",
                     cur_field, is_set_over, num_people, count_seconds, correct_point, mistake_point);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_range();
        test_back();
        test_abort();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
